pipeline_skid_register: RTL and testbench
=========================================

// Module: pipeline_skid_register
// PURPOSE
//   Generic elastic pipeline stage register, the parametrised successor to the fixed ID/EX latch.
//   Carries one WIDTH-bit packed stage bundle (PC, control, operands) between any two stages.
//   Uses a valid/ready handshake with a 2-entry skid buffer, so backpressure never drops data.
//   Supports flush-to-bubble and a saturating bubble counter for pipeline stall statistics.
// PARAMETERS
//   WIDTH      32  width of the packed stage bundle
//   NOP_VALUE  0   value of out_data whenever out_valid=0 (after reset or flush, or when empty)
//   CNT_W      16  width of the bubble counter
// PORTS
//   clk           in   1      rising-edge clock
//   reset         in   1      asynchronous, active-high; clears all state
//   flush         in   1      synchronous; kills all held entries at the next edge
//   in_valid      in   1      upstream has a bundle on in_data
//   in_ready      out  1      registered; stage can accept a bundle this cycle
//   in_data       in   WIDTH  upstream bundle
//   out_valid     out  1      registered; out_data holds a live bundle
//   out_ready     in   1      downstream accepts out_data this cycle
//   out_data      out  WIDTH  registered; oldest live bundle, else NOP_VALUE
//   occupancy     out  2      registered; live entries, 0..2
//   bubble_count  out  CNT_W  saturating count of cycles with out_ready=1 and out_valid=0
// BEHAVIOUR
// - One clock domain, clk. Reset is asynchronous and active-high.
// - Fire conditions:
//   - in_fire  = in_valid & in_ready
//   - out_fire = out_valid & out_ready
// - Storage: main register (drives out_data) plus skid register. FSM state in {EMPTY, ONE, FULL}.
//   - in_ready  = (state != FULL)
//   - out_valid = (state != EMPTY)
//   - occupancy = 0 / 1 / 2 for EMPTY / ONE / FULL
// - Transitions at the rising edge, evaluated only when flush=0:
//   - EMPTY: in_fire -> ONE, main<=in_data. Otherwise hold.
//   - ONE, in_fire & out_fire -> ONE, main<=in_data (back-to-back streaming, no bubble).
//   - ONE, in_fire & !out_fire -> FULL, skid<=in_data, main held.
//   - ONE, !in_fire & out_fire -> EMPTY, main<=NOP_VALUE.
//   - ONE, neither fires -> hold.
//   - FULL: in_fire is impossible. out_fire -> ONE, main<=skid, skid<=NOP_VALUE. Otherwise hold.
// - Latency: 1 cycle from in_fire to out_valid when empty. Throughput: 1 bundle per cycle while out_ready=1.
// - Flush has priority over every handshake:
//   - Next state EMPTY; main<=NOP_VALUE, skid<=NOP_VALUE.
//   - Any in_fire in the flush cycle is discarded (wrong-path bundle).
//   - An out_fire in the flush cycle is still consumed downstream; it is not replayed.
// - Reset mid-operation: immediately EMPTY, out_data=NOP_VALUE, skid=NOP_VALUE, bubble_count=0.
// - Reset values: in_ready=1, out_valid=0, out_data=NOP_VALUE, occupancy=0, bubble_count=0.
// - bubble_count:
//   - Increments on each edge where out_ready=1 and out_valid=0, including flush and reset-release cycles.
//   - Saturates at 2^CNT_W-1. Cleared only by reset.
// - Ordering: strict FIFO. No bundle is duplicated, reordered or lost unless a flush occurs.
// - out_data must be stable while out_valid=1 and out_ready=0.
// TESTING
// 1. Reset: reset=1 for 30ns, then release.
//    -> in_ready=1, out_valid=0, out_data=0, occupancy=0; bubble_count increments while out_ready=1.
// 2. Stream: out_ready=1; drive in_data 0xAAAA_AAAA, then 0xBBBB_BBBB on consecutive cycles.
//    -> each appears 1 cycle later; out_valid stays 1 with no gap; occupancy=1.
// 3. Backpressure: out_ready=0; push 0x5 then 0xA.
//    -> occupancy=2, in_ready=0, out_data holds 0x5.
//    Then raise out_ready. -> 0x5, then 0xA, then out_valid=0.
// 4. Flush while FULL, with a third bundle 0x1000_1000 offered in the same cycle.
//    -> next cycle out_valid=0, out_data=NOP_VALUE, occupancy=0.
//    -> 0x1000_1000 is never emitted.
// 5. Flush then refill: flush 1 cycle, then push 0x0000_00F0.
//    -> out_data=0x0000_00F0 on the cycle after acceptance.
// 6. Saturation: CNT_W=4, out_ready=1, idle 20 cycles.
//    -> bubble_count=15 and holds. Assert reset mid-stream -> all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/pipeline_skid_register.sv
// Elastic pipeline stage: valid/ready handshake backed by a main + skid register pair,
// with flush-to-bubble and a saturating count of downstream-ready-but-empty cycles.
module pipeline_skid_register #(
  parameter int              WIDTH     = 32,
  parameter logic [WIDTH-1:0] NOP_VALUE = '0,
  parameter int              CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       occupancy,
  output logic [CNT_W-1:0] bubble_count
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_main;
  logic [WIDTH-1:0]   w_main_next;
  logic [WIDTH-1:0]   r_skid;
  logic [WIDTH-1:0]   w_skid_next;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [1:0]         r_occupancy;
  logic [CNT_W-1:0]   r_bubble;

  logic w_in_fire;
  logic w_out_fire;
  logic w_bubble_sat;

  assign w_in_fire    = in_valid & r_in_ready;
  assign w_out_fire   = r_out_valid & out_ready;
  assign w_bubble_sat = &r_bubble;

  // Flush overrides the handshake; an accepted input in that cycle is a wrong-path bundle.
  always_comb begin
    w_state_next = r_state;
    w_main_next  = r_main;
    w_skid_next  = r_skid;
    if (flush) begin
      w_state_next = S_EMPTY;
      w_main_next  = NOP_VALUE;
      w_skid_next  = NOP_VALUE;
    end else begin
      case (r_state)
        S_EMPTY: begin
          if (w_in_fire) begin
            w_state_next = S_ONE;
            w_main_next  = in_data;
          end
        end
        S_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_next = in_data;
          end else if (w_in_fire) begin
            w_state_next = S_FULL;
            w_skid_next  = in_data;
          end else if (w_out_fire) begin
            w_state_next = S_EMPTY;
            w_main_next  = NOP_VALUE;
          end
        end
        S_FULL: begin
          if (w_out_fire) begin
            w_state_next = S_ONE;
            w_main_next  = r_skid;
            w_skid_next  = NOP_VALUE;
          end
        end
        default: begin
          w_state_next = S_EMPTY;
          w_main_next  = NOP_VALUE;
          w_skid_next  = NOP_VALUE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_EMPTY;
      r_main      <= NOP_VALUE;
      r_skid      <= NOP_VALUE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_occupancy <= 2'd0;
    end else begin
      r_state     <= w_state_next;
      r_main      <= w_main_next;
      r_skid      <= w_skid_next;
      r_in_ready  <= (w_state_next != S_FULL);
      r_out_valid <= (w_state_next != S_EMPTY);
      r_occupancy <= w_state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble <= '0;
    end else if (out_ready && !r_out_valid && !w_bubble_sat) begin
      r_bubble <= r_bubble + CNT_W'(1);
    end
  end

  assign in_ready     = r_in_ready;
  assign out_valid    = r_out_valid;
  assign out_data     = r_main;
  assign occupancy    = r_occupancy;
  assign bubble_count = r_bubble;

endmodule

// File: tb/tb_pipeline_skid_register.sv
// Directed bench for pipeline_skid_register: per-scenario vector tables with expected
// in_ready/out_valid/occupancy/out_data after each clock edge, plus bubble counter checks.
module tb_pipeline_skid_register;

  localparam int WIDTH = 32;
  localparam int CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       occupancy;
  logic [CNT_W-1:0] bubble_count;

  int n_vec = 0;
  int n_err = 0;

  // One vector: inputs applied before an edge, outputs expected just after it.
  typedef struct packed {
    logic        fl;
    logic        iv;
    logic [31:0] id;
    logic        ordy;
    logic        erdy;
    logic        evld;
    logic [1:0]  eocc;
    logic [31:0] edata;
  } vec_t;

  pipeline_skid_register #(
    .WIDTH    (WIDTH),
    .NOP_VALUE(32'h0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .occupancy   (occupancy),
    .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #29;
    n_vec++;
    if ({in_ready, out_valid, occupancy, out_data, bubble_count} !== {1'b1, 1'b0, 2'd0, 32'h0, 4'd0}) begin
      n_err++;
      $display("FAIL reset_values: got rdy=%0b vld=%0b occ=%0d data=%h bub=%0d, want rdy=1 vld=0 occ=0 data=00000000 bub=0",
               in_ready, out_valid, occupancy, out_data, bubble_count);
    end
    $display("reset_values: rdy=%0b vld=%0b occ=%0d data=%h bub=%0d", in_ready, out_valid, occupancy, out_data, bubble_count);
    #1;
    reset = 1'b0; out_ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      n_vec++;
      if ({out_valid, bubble_count} !== {1'b0, 4'(k)}) begin
        n_err++;
        $display("FAIL reset_bubble[%0d]: got vld=%0b bub=%0d, want vld=0 bub=%0d", k, out_valid, bubble_count, k);
      end
      $display("reset_bubble[%0d]: vld=%0b bub=%0d", k, out_valid, bubble_count);
    end
  endtask

  task automatic test_stream();
    vec_t v [3];
    v[0] = '{1'b0, 1'b1, 32'hAAAA_AAAA, 1'b1, 1'b1, 1'b1, 2'd1, 32'hAAAA_AAAA};
    v[1] = '{1'b0, 1'b1, 32'hBBBB_BBBB, 1'b1, 1'b1, 1'b1, 2'd1, 32'hBBBB_BBBB};
    v[2] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 2'd0, 32'h0};
    foreach (v[i]) begin
      flush = v[i].fl; in_valid = v[i].iv; in_data = v[i].id; out_ready = v[i].ordy;
      step();
      n_vec++;
      if ({in_ready, out_valid, occupancy, out_data} !== {v[i].erdy, v[i].evld, v[i].eocc, v[i].edata}) begin
        n_err++;
        $display("FAIL stream[%0d]: got rdy=%0b vld=%0b occ=%0d data=%h, want rdy=%0b vld=%0b occ=%0d data=%h",
                 i, in_ready, out_valid, occupancy, out_data, v[i].erdy, v[i].evld, v[i].eocc, v[i].edata);
      end
      $display("stream[%0d]: rdy=%0b vld=%0b occ=%0d data=%h", i, in_ready, out_valid, occupancy, out_data);
    end
  endtask

  task automatic test_backpressure();
    vec_t v [5];
    v[0] = '{1'b0, 1'b1, 32'h5, 1'b0, 1'b1, 1'b1, 2'd1, 32'h5};
    v[1] = '{1'b0, 1'b1, 32'hA, 1'b0, 1'b0, 1'b1, 2'd2, 32'h5};
    v[2] = '{1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1, 2'd2, 32'h5};
    v[3] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 2'd1, 32'hA};
    v[4] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0};
    foreach (v[i]) begin
      flush = v[i].fl; in_valid = v[i].iv; in_data = v[i].id; out_ready = v[i].ordy;
      step();
      n_vec++;
      if ({in_ready, out_valid, occupancy, out_data} !== {v[i].erdy, v[i].evld, v[i].eocc, v[i].edata}) begin
        n_err++;
        $display("FAIL backpressure[%0d]: got rdy=%0b vld=%0b occ=%0d data=%h, want rdy=%0b vld=%0b occ=%0d data=%h",
                 i, in_ready, out_valid, occupancy, out_data, v[i].erdy, v[i].evld, v[i].eocc, v[i].edata);
      end
      $display("backpressure[%0d]: rdy=%0b vld=%0b occ=%0d data=%h", i, in_ready, out_valid, occupancy, out_data);
    end
  endtask

  task automatic test_flush_full();
    vec_t v [5];
    v[0] = '{1'b0, 1'b1, 32'h11,        1'b0, 1'b1, 1'b1, 2'd1, 32'h11};
    v[1] = '{1'b0, 1'b1, 32'h22,        1'b0, 1'b0, 1'b1, 2'd2, 32'h11};
    v[2] = '{1'b1, 1'b1, 32'h1000_1000, 1'b0, 1'b1, 1'b0, 2'd0, 32'h0};
    v[3] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 2'd0, 32'h0};
    v[4] = '{1'b0, 1'b0, 32'h0,         1'b1, 1'b1, 1'b0, 2'd0, 32'h0};
    foreach (v[i]) begin
      flush = v[i].fl; in_valid = v[i].iv; in_data = v[i].id; out_ready = v[i].ordy;
      step();
      n_vec++;
      if ({in_ready, out_valid, occupancy, out_data} !== {v[i].erdy, v[i].evld, v[i].eocc, v[i].edata}) begin
        n_err++;
        $display("FAIL flush_full[%0d]: got rdy=%0b vld=%0b occ=%0d data=%h, want rdy=%0b vld=%0b occ=%0d data=%h",
                 i, in_ready, out_valid, occupancy, out_data, v[i].erdy, v[i].evld, v[i].eocc, v[i].edata);
      end
      $display("flush_full[%0d]: rdy=%0b vld=%0b occ=%0d data=%h", i, in_ready, out_valid, occupancy, out_data);
    end
  endtask

  task automatic test_flush_refill();
    vec_t v [4];
    v[0] = '{1'b1, 1'b1, 32'hDEAD, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0};
    v[1] = '{1'b0, 1'b1, 32'hF0,   1'b1, 1'b1, 1'b1, 2'd1, 32'hF0};
    v[2] = '{1'b1, 1'b1, 32'h77,   1'b1, 1'b1, 1'b0, 2'd0, 32'h0};
    v[3] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 2'd0, 32'h0};
    foreach (v[i]) begin
      flush = v[i].fl; in_valid = v[i].iv; in_data = v[i].id; out_ready = v[i].ordy;
      step();
      n_vec++;
      if ({in_ready, out_valid, occupancy, out_data} !== {v[i].erdy, v[i].evld, v[i].eocc, v[i].edata}) begin
        n_err++;
        $display("FAIL flush_refill[%0d]: got rdy=%0b vld=%0b occ=%0d data=%h, want rdy=%0b vld=%0b occ=%0d data=%h",
                 i, in_ready, out_valid, occupancy, out_data, v[i].erdy, v[i].evld, v[i].eocc, v[i].edata);
      end
      $display("flush_refill[%0d]: rdy=%0b vld=%0b occ=%0d data=%h", i, in_ready, out_valid, occupancy, out_data);
    end
    flush = 1'b0;
  endtask

  task automatic test_back_to_back();
    vec_t v [5];
    v[0] = '{1'b0, 1'b1, 32'h1, 1'b0, 1'b1, 1'b1, 2'd1, 32'h1};
    v[1] = '{1'b0, 1'b1, 32'h2, 1'b0, 1'b0, 1'b1, 2'd2, 32'h1};
    v[2] = '{1'b0, 1'b1, 32'h3, 1'b1, 1'b1, 1'b1, 2'd1, 32'h2};
    v[3] = '{1'b0, 1'b1, 32'h3, 1'b1, 1'b1, 1'b1, 2'd1, 32'h3};
    v[4] = '{1'b0, 1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 2'd0, 32'h0};
    foreach (v[i]) begin
      flush = v[i].fl; in_valid = v[i].iv; in_data = v[i].id; out_ready = v[i].ordy;
      step();
      n_vec++;
      if ({in_ready, out_valid, occupancy, out_data} !== {v[i].erdy, v[i].evld, v[i].eocc, v[i].edata}) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got rdy=%0b vld=%0b occ=%0d data=%h, want rdy=%0b vld=%0b occ=%0d data=%h",
                 i, in_ready, out_valid, occupancy, out_data, v[i].erdy, v[i].evld, v[i].eocc, v[i].edata);
      end
      $display("back_to_back[%0d]: rdy=%0b vld=%0b occ=%0d data=%h", i, in_ready, out_valid, occupancy, out_data);
    end
  endtask

  task automatic test_saturate();
    int exp_b;
    flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    reset = 1'b1;
    #1;
    n_vec++;
    if (bubble_count !== 4'd0) begin
      n_err++;
      $display("FAIL sat_clear: got bub=%0d, want bub=0", bubble_count);
    end
    $display("sat_clear: bub=%0d", bubble_count);
    #3;
    reset = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      step();
      exp_b = (k < 15) ? k : 15;
      n_vec++;
      if (bubble_count !== 4'(exp_b)) begin
        n_err++;
        $display("FAIL sat_count[%0d]: got bub=%0d, want bub=%0d", k, bubble_count, exp_b);
      end
      $display("sat_count[%0d]: bub=%0d", k, bubble_count);
    end
    // Fill to FULL, then assert reset between edges and expect outputs to clear at once.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h33;
    step();
    in_data = 32'h44;
    step();
    in_valid = 1'b0;
    n_vec++;
    if ({in_ready, out_valid, occupancy, out_data} !== {1'b0, 1'b1, 2'd2, 32'h33}) begin
      n_err++;
      $display("FAIL sat_fill: got rdy=%0b vld=%0b occ=%0d data=%h, want rdy=0 vld=1 occ=2 data=00000033",
               in_ready, out_valid, occupancy, out_data);
    end
    $display("sat_fill: rdy=%0b vld=%0b occ=%0d data=%h", in_ready, out_valid, occupancy, out_data);
    #2;
    reset = 1'b1;
    #1;
    n_vec++;
    if ({in_ready, out_valid, occupancy, out_data, bubble_count} !== {1'b1, 1'b0, 2'd0, 32'h0, 4'd0}) begin
      n_err++;
      $display("FAIL async_reset: got rdy=%0b vld=%0b occ=%0d data=%h bub=%0d, want rdy=1 vld=0 occ=0 data=00000000 bub=0",
               in_ready, out_valid, occupancy, out_data, bubble_count);
    end
    $display("async_reset: rdy=%0b vld=%0b occ=%0d data=%h bub=%0d", in_ready, out_valid, occupancy, out_data, bubble_count);
    #2;
    reset = 1'b0;
    out_ready = 1'b1;
    step();
    n_vec++;
    if ({out_valid, occupancy, out_data} !== {1'b0, 2'd0, 32'h0}) begin
      n_err++;
      $display("FAIL post_reset_empty: got vld=%0b occ=%0d data=%h, want vld=0 occ=0 data=00000000",
               out_valid, occupancy, out_data);
    end
    $display("post_reset_empty: vld=%0b occ=%0d data=%h", out_valid, occupancy, out_data);
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush_full();
    test_flush_refill();
    test_back_to_back();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
